// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl
// ---------------------------------------------------------------------------
// Multi-cycle sequencer around the CPU's 32-bit combinational restoring
// divider (div32). Latches signed operands, hands their magnitudes to the
// divider, waits SETTLE_CYCLES for its multicycle path, then applies signs
// and writes HI (remainder) and LO (quotient). Divide-by-zero and a divisor
// of 0x80000000 are resolved here and never reach the divider.
//
// Parameter:
//   SETTLE_CYCLES  cycles div_z must be stable before capture (legal 1..15)
//
// Optional feature macro: DIV_ZERO_TRAP_EN
//   defined   -> extra output dz_trap pulses with done on divide-by-zero and
//                HI/LO keep their prior values
//   undefined -> divide-by-zero writes lo=0xFFFFFFFF, hi=op_a
//
// Ports:
//   clock      in   system clock, rising edge
//   clear      in   asynchronous active-low reset
//   start      in   request, accepted only while ready=1
//   op_a/op_b  in   signed dividend / divisor
//   ready      out  idle, can accept start
//   busy       out  operation in progress (~ready)
//   done       out  one-cycle pulse, coincident with the HI/LO update
//   hi/lo      out  remainder / quotient registers
//   div_a/b    out  dividend / divisor magnitudes to the divider
//   div_z      in   divider result {remainder[63:32], quotient[31:0]}
//   dz_flag    out  last op was divide-by-zero (sticky until next start)
//   dz_trap    out  (DIV_ZERO_TRAP_EN only) divide-by-zero trap pulse
//   state_dbg  out  current FSM state (IDLE=0, LOAD=1, SETTLE=2, FIX=3)
//
// Handshake: a request transfers on a rising edge where start=1 and
// ready=1; start while ready=0 is ignored, nothing is queued.
// ---------------------------------------------------------------------------
module div_hilo_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   input  logic [63:0] div_z,
   output logic        dz_flag,
`ifdef DIV_ZERO_TRAP_EN
   output logic        dz_trap,
`endif
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SETTLE = 2'd2,
      FIX    = 2'd3
   } state_t;

   localparam logic [31:0] MIN_INT  = 32'h8000_0000;
   localparam logic [3:0]  CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t      state, state_nx;
   logic [31:0] a_q, b_q;
   logic        sign_q, sign_r;
   logic [3:0]  cnt;
   logic        forced, dz_op;
   logic [31:0] fq, fr;
   logic        special;
   logic [31:0] mag_a, mag_b;
   logic [31:0] q_raw, r_raw;

   // Two's-complement negation of 0x80000000 wraps back to itself, which is
   // exactly the unsigned magnitude the divider wants.
   assign mag_a   = a_q[31] ? -a_q : a_q;
   assign mag_b   = b_q[31] ? -b_q : b_q;
   assign special = (b_q == 32'd0) || (b_q == MIN_INT);
   assign q_raw   = div_z[31:0];
   assign r_raw   = div_z[63:32];

   assign ready     = (state == IDLE);
   assign busy      = ~ready;
   assign state_dbg = state;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD:    state_nx = special ? FIX : SETTLE;
         SETTLE:  if (cnt == 4'd0) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         a_q     <= '0;
         b_q     <= '0;
         sign_q  <= 1'b0;
         sign_r  <= 1'b0;
         cnt     <= '0;
         forced  <= 1'b0;
         dz_op   <= 1'b0;
         fq      <= '0;
         fr      <= '0;
         div_a   <= '0;
         div_b   <= '0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
         dz_flag <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
         dz_trap <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
         dz_trap <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (start) begin
                  a_q     <= op_a;
                  b_q     <= op_b;
                  sign_q  <= op_a[31] ^ op_b[31];
                  sign_r  <= op_a[31];
                  dz_flag <= 1'b0;
               end
            end
            LOAD: begin
               forced <= special;
               dz_op  <= (b_q == 32'd0);
               if (b_q == 32'd0) begin
                  fq      <= 32'hFFFF_FFFF;
                  fr      <= a_q;
                  dz_flag <= 1'b1;
               end else if (b_q == MIN_INT) begin
                  // Only MIN_INT itself has magnitude >= 2^31.
                  fq <= (a_q == MIN_INT) ? 32'd1 : 32'd0;
                  fr <= (a_q == MIN_INT) ? 32'd0 : a_q;
               end else begin
                  div_a <= mag_a;
                  div_b <= mag_b;
                  cnt   <= CNT_INIT;
               end
            end
            SETTLE: begin
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
            end
            FIX: begin
               done <= 1'b1;
               if (forced) begin
`ifdef DIV_ZERO_TRAP_EN
                  if (dz_op) begin
                     dz_trap <= 1'b1;
                  end else begin
                     lo <= fq;
                     hi <= fr;
                  end
`else
                  lo <= fq;
                  hi <= fr;
`endif
               end else begin
                  lo <= sign_q ? -q_raw : q_raw;
                  hi <= sign_r ? -r_raw : r_raw;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// tb_div_hilo_ctrl
// ---------------------------------------------------------------------------
// Directed bench for div_hilo_ctrl with SETTLE_CYCLES=4. A behavioural
// unsigned divider stands in for div32. Each scenario task drives its
// vectors and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_div_hilo_ctrl;

   localparam int unsigned SC = 4;

   logic        clock = 1'b0;
   logic        clear;
   logic        start;
   logic [31:0] op_a, op_b;
   logic        ready, busy, done;
   logic [31:0] hi, lo, div_a, div_b;
   logic [63:0] div_z;
   logic        dz_flag;
   logic [1:0]  state_dbg;
`ifdef DIV_ZERO_TRAP_EN
   logic        dz_trap;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;

   // clock / reset block
   always #5 clock = ~clock;

   // behavioural stand-in for the combinational divider
   always_comb begin
      if (div_b == 32'd0) div_z = 64'd0;
      else                div_z = {div_a % div_b, div_a / div_b};
   end

   always @(negedge clock) if (done) done_cnt++;

   div_hilo_ctrl #(.SETTLE_CYCLES(SC)) dut (
      .clock     (clock),
      .clear     (clear),
      .start     (start),
      .op_a      (op_a),
      .op_b      (op_b),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .div_a     (div_a),
      .div_b     (div_b),
      .div_z     (div_z),
      .dz_flag   (dz_flag),
`ifdef DIV_ZERO_TRAP_EN
      .dz_trap   (dz_trap),
`endif
      .state_dbg (state_dbg)
   );

   // driver: issue one request, return edges from accept to done (-1 = timeout)
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat);
      @(negedge clock);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clock);
         #1;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      clear = 1'b0;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      repeat (3) @(posedge clock);
      #1;
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
      n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
      n_cmp++; if ({div_a, div_b} !== 64'd0) begin n_err++; $display("FAIL reset_div got %h/%h want 0/0", div_a, div_b); end
      n_cmp++; if (dz_flag !== 1'b0) begin n_err++; $display("FAIL reset_dz got %b want 0", dz_flag); end
      n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state_dbg); end
      @(negedge clock);
      clear = 1'b1;
   endtask

   task automatic test_basic;
      int lat;
      do_op(32'd100, 32'd7, lat);
      n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL basic_latency got %0d want 6", lat); end
      n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL basic_lo got %h want 0000000e", lo); end
      n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL basic_hi got %h want 00000002", hi); end
      n_cmp++; if (dz_flag !== 1'b0) begin n_err++; $display("FAIL basic_dz got %b want 0", dz_flag); end
      n_cmp++; if ({div_a, div_b} !== {32'd100, 32'd7}) begin n_err++; $display("FAIL basic_div got %h/%h want 64/7", div_a, div_b); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL basic_ready got %b want 1", ready); end
   endtask

   task automatic test_signs;
      int lat;
      do_op(-32'sd100, 32'd7, lat);
      n_cmp++; if (lo !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL neg_div_lo got %h want fffffff2", lo); end
      n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL neg_div_hi got %h want fffffffe", hi); end
      n_cmp++; if (div_a !== 32'd100) begin n_err++; $display("FAIL neg_div_mag got %h want 00000064", div_a); end
      do_op(32'd100, -32'sd7, lat);
      n_cmp++; if (lo !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL neg_dvs_lo got %h want fffffff2", lo); end
      n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL neg_dvs_hi got %h want 00000002", hi); end
      do_op(-32'sd100, -32'sd7, lat);
      n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL neg_both_lo got %h want 0000000e", lo); end
      n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL neg_both_hi got %h want fffffffe", hi); end
      n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL neg_both_latency got %0d want 6", lat); end
   endtask

   task automatic test_div_zero;
      int lat;
      // previous op left lo=14, hi=-2
      do_op(32'd55, 32'd0, lat);
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL dz_latency got %0d want 2", lat); end
      n_cmp++; if (dz_flag !== 1'b1) begin n_err++; $display("FAIL dz_flag got %b want 1", dz_flag); end
`ifdef DIV_ZERO_TRAP_EN
      n_cmp++; if (dz_trap !== 1'b1) begin n_err++; $display("FAIL dz_trap got %b want 1", dz_trap); end
      n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL dz_lo_kept got %h want 0000000e", lo); end
      n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL dz_hi_kept got %h want fffffffe", hi); end
`else
      n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dz_lo got %h want ffffffff", lo); end
      n_cmp++; if (hi !== 32'd55) begin n_err++; $display("FAIL dz_hi got %h want 00000037", hi); end
`endif
      // flag is sticky until the next accepted start
      repeat (3) @(posedge clock);
      #1;
      n_cmp++; if (dz_flag !== 1'b1) begin n_err++; $display("FAIL dz_sticky got %b want 1", dz_flag); end
      do_op(32'd9, 32'd2, lat);
      n_cmp++; if (dz_flag !== 1'b0) begin n_err++; $display("FAIL dz_cleared got %b want 0", dz_flag); end
      n_cmp++; if ({hi, lo} !== {32'd1, 32'd4}) begin n_err++; $display("FAIL dz_next_op got %h/%h want 1/4", hi, lo); end
   endtask

   task automatic test_min_int;
      int lat;
      do_op(32'h8000_0000, 32'h8000_0000, lat);
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL min_min_latency got %0d want 2", lat); end
      n_cmp++; if ({hi, lo} !== {32'd0, 32'd1}) begin n_err++; $display("FAIL min_min got %h/%h want 0/1", hi, lo); end
      do_op(32'd5, 32'h8000_0000, lat);
      n_cmp++; if ({hi, lo} !== {32'd5, 32'd0}) begin n_err++; $display("FAIL five_min got %h/%h want 5/0", hi, lo); end
      do_op(-32'sd5, 32'h8000_0000, lat);
      n_cmp++; if ({hi, lo} !== {32'hFFFF_FFFB, 32'd0}) begin n_err++; $display("FAIL negfive_min got %h/%h want fffffffb/0", hi, lo); end
      n_cmp++; if (dz_flag !== 1'b0) begin n_err++; $display("FAIL min_dz got %b want 0", dz_flag); end
      do_op(32'h8000_0000, 32'hFFFF_FFFF, lat);
      n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL min_m1_latency got %0d want 6", lat); end
      n_cmp++; if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin n_err++; $display("FAIL min_m1 got %h/%h want 0/80000000", hi, lo); end
      n_cmp++; if (dz_flag !== 1'b0) begin n_err++; $display("FAIL min_m1_dz got %b want 0", dz_flag); end
   endtask

   task automatic test_abort;
      int d0;
      @(negedge clock);
      op_a  = 32'd9;
      op_b  = 32'd3;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      n_cmp++; if (state_dbg !== 2'd2) begin n_err++; $display("FAIL abort_in_settle got %0d want 2", state_dbg); end
      d0 = done_cnt;
      #2 clear = 1'b0;
      #1;
      n_cmp++; if (ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL abort_ready got %b/%b want 1/0", ready, busy); end
      n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL abort_hilo got %h/%h want 0/0", hi, lo); end
      n_cmp++; if ({div_a, div_b} !== 64'd0) begin n_err++; $display("FAIL abort_div got %h/%h want 0/0", div_a, div_b); end
      n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL abort_state got %0d want 0", state_dbg); end
      @(negedge clock);
      clear = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL abort_no_done got %0d want %0d", done_cnt, d0); end
      n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL abort_hilo_after got %h/%h want 0/0", hi, lo); end
   endtask

   task automatic test_back_to_back;
      int d0, lat;
      d0 = done_cnt;
      @(negedge clock);
      op_a  = 32'd20;
      op_b  = 32'd6;
      start = 1'b1;
      @(posedge clock);
      // start stays high while busy; operands change to show they were latched
      #1 op_a = 32'd999;
      op_b = 32'd1;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clock);
         #1;
         if (done) begin lat = n; break; end
      end
      n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL b2b_first_latency got %0d want 6", lat); end
      n_cmp++; if ({hi, lo} !== {32'd2, 32'd3}) begin n_err++; $display("FAIL b2b_first got %h/%h want 2/3", hi, lo); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_at_done got %b want 1", ready); end
      op_a = -32'sd21;
      op_b = 32'd4;
      @(posedge clock);
      #1 start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clock);
         #1;
         if (done) begin lat = n; break; end
      end
      n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL b2b_second_latency got %0d want 6", lat); end
      n_cmp++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFB}) begin n_err++; $display("FAIL b2b_second got %h/%h want ffffffff/fffffffb", hi, lo); end
      repeat (8) @(posedge clock);
      #1;
      n_cmp++; if (done_cnt - d0 !== 2) begin n_err++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - d0); end
      n_cmp++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFB}) begin n_err++; $display("FAIL b2b_hold got %h/%h want ffffffff/fffffffb", hi, lo); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_signs;
      test_div_zero;
      test_min_int;
      test_abort;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/div_hilo_ctrl.md
Name: div_hilo_ctrl

Overview:
- Multi-cycle sequencer wrapped around the CPU's 32-bit combinational restoring divider (div32).
- Upstream: latches signed operands from the datapath, converts them to magnitudes, drives the divider, and waits for its multicycle path to settle.
- Downstream: captures the divider's 64-bit {remainder, quotient} result, applies signs, and writes the HI (remainder) and LO (quotient) registers.
- Handles divide-by-zero and the |divisor| = 2^31 cases itself; the divider never receives them.

Parameters:
SETTLE_CYCLES, 4, cycles div_z must be stable before capture; legal range 1..15.

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-low reset
start  in  1  request; accepted only when ready=1
op_a  in  32  signed dividend
op_b  in  32  signed divisor
ready  out  1  idle, can accept start
busy  out  1  operation in progress
done  out  1  one-cycle pulse when HI/LO updated
hi  out  32  remainder register
lo  out  32  quotient register
div_a  out  32  dividend magnitude to divider
div_b  out  32  divisor magnitude to divider
div_z  in  64  divider result {remainder[63:32], quotient[31:0]}
dz_flag  out  1  last op was divide-by-zero (sticky until next accepted start)

Behaviour:
- Reset (clear=0, async): state=IDLE, hi=0, lo=0, div_a=0, div_b=0, done=0, busy=0, ready=1, dz_flag=0, settle counter=0. Reset mid-operation aborts; no HI/LO write.
- States: IDLE -> LOAD -> SETTLE -> FIX -> IDLE.
- IDLE: ready=1. On start, register op_a, op_b, sign_q = op_a[31]^op_b[31], sign_r = op_a[31]; clear dz_flag; go to LOAD. start while busy is ignored (no queueing).
- LOAD (1 cycle): div_a = |op_a|, div_b = |op_b|, both unsigned; |0x80000000| = 0x80000000. Special cases bypass SETTLE and go straight to FIX with a forced result:
  - op_b==0: q=0xFFFFFFFF, r=op_a raw, no sign fix, dz_flag=1.
  - op_b==0x80000000: q = (op_a==0x80000000) ? 1 : 0, r = (op_a==0x80000000) ? 0 : op_a raw, no sign fix.
  - Otherwise, load counter=SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE: div_a/div_b held constant. Decrement counter each cycle; at 0 go to FIX. Occupies exactly SETTLE_CYCLES cycles.
- FIX (1 cycle): for the normal path, q=div_z[31:0], r=div_z[63:32]; lo <= sign_q ? -q : q, hi <= sign_r ? -r : r (two's complement, 32-bit wrap). Forced results are written as-is. done=1 in the same cycle hi/lo update; return to IDLE.
- Semantics: truncation toward zero; remainder sign follows dividend. 0x80000000 / -1 gives lo=0x80000000, hi=0 by natural wrap, no flag.
- Latency, start edge to done: normal = 2+SETTLE_CYCLES cycles; special case = 2 cycles. ready=0 from the cycle after start is accepted until FIX completes; ready and start may be re-asserted in the cycle after done.
- hi/lo hold their value between operations; only FIX writes them.
- busy = ~ready.

Optional Feature:
DIV_ZERO_TRAP_EN
- Defined: adds output dz_trap (1 bit), pulsed with done on divide-by-zero. In this case hi/lo are NOT written and keep their prior values; dz_flag still sets.
- Undefined: no dz_trap port; divide-by-zero writes the forced result (lo=0xFFFFFFFF, hi=op_a).

Test Plan:
- Reset then 100/7, SETTLE_CYCLES=4 -> done at cycle 6 after start; lo=14, hi=2; dz_flag=0.
- -100/7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); 100/-7 -> lo=-14, hi=2.
- 55/0 -> done after 2 cycles; lo=0xFFFFFFFF, hi=55, dz_flag=1 (with DIV_ZERO_TRAP_EN: dz_trap pulse, hi/lo unchanged).
- 0x80000000/0x80000000 -> lo=1, hi=0. 5/0x80000000 -> lo=0, hi=5. 0x80000000/-1 -> lo=0x80000000, hi=0.
- Assert clear during SETTLE of 9/3 -> all outputs return to reset values immediately; hi/lo stay 0.
- start held high during busy, then a back-to-back start on the cycle after done -> only one op per accept; second op's result correct, no lost done.
